instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Fetch-side master of the instruction code memory. Drives the byte address pc_o, which the memory samples every cycle.
//  Captures the returned word, which arrives registered one cycle later.
//  Buffers fetched words in a small FIFO and presents them to decode with a valid/ready handshake.
//  Handles branch redirect (flush), halt, and 32-bit PC wrap.
// PARAMETERS
//  RESET_PC   32'h0000_0000  byte address of first fetch after reset
//  BUF_DEPTH  2              FIFO entries; power of 2, >=2 (2 = full throughput)
// PORTS
//  clk              in   1   clock, all state on posedge
//  reset            in   1   synchronous, active-high
//  pc_o             out  32  fetch address to code memory (word aligned)
//  inst_i           in   32  memory word for pc_o of previous cycle
//  inst_o           out  32  instruction at FIFO head
//  inst_pc_o        out  32  byte address of inst_o
//  inst_pc8_o       out  32  inst_pc_o + 8 (r15 read value), mod 2^32
//  valid_o          out  1   FIFO head valid
//  ready_i          in   1   decode accepts head; pop = valid_o & ready_i
//  branch_i         in   1   redirect request (1-cycle pulse)
//  branch_target_i  in   32  redirect byte address; bits[1:0] forced to 0
//  halt_i           in   1   stop issuing new fetches
// BEHAVIOUR
//  - Reset (sync, high): pc_o=RESET_PC, valid_o=0, inst_o/inst_pc_o=0, inst_pc8_o=8, FIFO empty, inflight=0, state=BOOT.
//    Reset mid-operation discards FIFO and inflight word.
//  - States:
//    BOOT->RUN unconditionally (no issue in BOOT).
//    RUN->HALT when halt_i=1 (that cycle issues nothing).
//    HALT->RUN only on branch_i. halt_i is ignored outside RUN; branch_i has priority over halt_i.
//  - Issue (RUN only): issue = (count + inflight - pop) < BUF_DEPTH.
//    On issue, next pc_o = pc_o+4, mod 2^32 (0xFFFF_FFFC wraps to 0), and inflight<=1, with tag<=pc_o.
//    Otherwise pc_o holds and inflight<=0.
//  - Capture: if inflight=1, push {inst_i, tag} into FIFO that cycle. Push and pop in the same cycle are legal.
//    Count is never exceeded, by construction of the issue rule.
//  - Outputs inst_o/inst_pc_o/inst_pc8_o are from the FIFO head. They are held stable while valid_o & !ready_i.
//  - Redirect: branch_i in cycle t:
//    - pop of head in cycle t still counts as accepted.
//    - t+1: FIFO empty, valid_o=0, inflight=0, pc_o={target[31:2],2'b00}, state=RUN.
//    - The word arriving at t+1 is dropped; the target is issued at t+1, captured t+2, valid_o=1 at t+3.
//  - Steady state, ready_i=1, BUF_DEPTH=2: one instruction per cycle, first valid_o 3 cycles after reset release.
//  - halt_i and ready_i never drop a captured word; HALT drains the FIFO normally.
// CONFIGURATION
//  IFETCH_PERF_CNT_EN defined:
//    - adds out ports fetch_cnt_o[31:0] (+1 per issue) and flush_cnt_o[15:0] (+count+inflight on each branch_i).
//    - both counters are 0 on reset, saturate at max, and do not wrap.
//  Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1 reset held 2 cycles then released, ready_i=1, memory mem[a]=a -> pc_o 0,0,4,8,...;
//    valid_o first high cycle 3 with inst_o=0, then inst_pc_o 0,4,8 consecutively; inst_pc8_o=inst_pc_o+8.
//  2 ready_i=0 from cycle 5 for 4 cycles -> count reaches 2, pc_o freezes, inst_o held;
//    ready_i=1 -> sequence resumes without gap or duplicate.
//  3 branch_i=1 with branch_target_i=0x13 while FIFO full -> next cycle valid_o=0, pc_o=0x10;
//    two cycles later valid_o=1, inst_pc_o=0x10; no stale word delivered.
//  4 branch_i coincident with pop -> popped word counted accepted, all later words come from target.
//  5 halt_i=1 in RUN -> no further pc_o change, FIFO drains, valid_o=0;
//    branch_i to 0x40 -> fetch resumes at 0x40.
//  6 RESET_PC=32'hFFFF_FFF8 -> inst_pc_o FFFF_FFF8, FFFF_FFFC, 0000_0000.
//    With IFETCH_PERF_CNT_EN, fetch_cnt_o equals issues, and flush_cnt_o=2 after test 3's branch.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch master with prefetch FIFO, redirect, halt and PC wrap
// Optional feature macro: IFETCH_PERF_CNT_EN (adds saturating fetch/flush counters fetch_cnt_o, flush_cnt_o)
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_o,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_pc8_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        halt_i
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     tag_q, tag_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     data_mem_q [BUF_DEPTH];
    logic [31:0]     pc_mem_q   [BUF_DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occupancy;

    assign pop       = (count_q != '0) && ready_i;
    assign push      = inflight_q;
    // Slots already promised: buffered words plus the word in flight, minus the one leaving now.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    // A redirect cancels issue that cycle; the fetched word would be discarded anyway.
    assign issue     = (state_q == ST_RUN) && !halt_i && !branch_i && (occupancy < DEPTH_W);

    assign pc_o       = pc_q;
    assign valid_o    = (count_q != '0);
    assign inst_o     = data_mem_q[rd_ptr_q];
    assign inst_pc_o  = pc_mem_q[rd_ptr_q];
    assign inst_pc8_o = pc_mem_q[rd_ptr_q] + 32'd8;

    // Control state register, fetch PC, in-flight tracking and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC & 32'hFFFF_FFFC;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Next-state logic: FSM transitions, PC advance/redirect and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_i) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase

        if (branch_i) begin
            // Redirect wins over halt and flushes both buffered and in-flight words.
            state_d  = ST_RUN;
            pc_d     = branch_target_i & 32'hFFFF_FFFC;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + 32'd4;
                inflight_d = 1'b1;
                tag_d      = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // FIFO storage: captures the returned word together with the address it was fetched from.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (push && !branch_i) begin
            data_mem_q[wr_ptr_q] <= inst_i;
            pc_mem_q[wr_ptr_q]   <= tag_q;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;
    logic [16:0] flush_sum;

    assign flush_sum   = {1'b0, flush_cnt_q} + {{(17-CW){1'b0}}, count_q} + {16'd0, inflight_q};
    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // Saturating counters: issued fetches and words discarded by redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (issue && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (branch_i) flush_cnt_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end
`endif

endmodule
